// File: rtl/hash_table_pkg.sv
// Shared hash-table types: the search task handed from the command front end
// to the data_table_search engines, plus table geometry constants.
package hash_table;

   localparam int TABLE_ADDR_WIDTH = 10;
   localparam int KEY_WIDTH        = 16;
   localparam int ENGINES_CNT_MAX  = 8;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]        key;
      logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
      logic                        head_ptr_val;
   } ht_task_t;

endpackage

// File: rtl/data_table_search_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr and moves
// ptr just past the winner when advance is asserted.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int PW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] gnt_idx;
   logic          found;
   int            idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
         end
      end
   end

   // Winner drops to lowest priority for the next round
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ptr <= '0;
      else if (advance && found)
         ptr <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/data_table_search_sched.sv
// Dispatches search tasks to idle engines and shares the single data-table
// RAM read port between them, tagging each read so only its issuer sees valid.
module data_table_search_sched
   import hash_table::*;
#(
   parameter  int ENGINES_CNT = 3,
   parameter  int RAM_LATENCY = 2,
   parameter  int A_WIDTH     = TABLE_ADDR_WIDTH,
   localparam int CW          = $clog2(ENGINES_CNT+1),
   localparam int PW          = $clog2(ENGINES_CNT)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  ht_task_t                       task_i,
   input  logic                           task_valid_i,
   output logic                           task_ready_o,
   output ht_task_t                       eng_task_o,
   output logic [ENGINES_CNT-1:0]         eng_task_run_o,
   input  logic [ENGINES_CNT-1:0]         eng_busy_i,
   input  logic [ENGINES_CNT-1:0]         eng_rd_req_i,
   input  logic [ENGINES_CNT*A_WIDTH-1:0] eng_rd_addr_i,
   output logic [ENGINES_CNT-1:0]         eng_rd_gnt_o,
   output logic [ENGINES_CNT-1:0]         eng_rd_data_val_o,
   output logic [A_WIDTH-1:0]             rd_addr_o,
   output logic                           rd_en_o,
   output logic [CW-1:0]                  active_cnt_o
);

   logic [ENGINES_CNT-1:0] pending;
   logic [ENGINES_CNT-1:0] idle;
   logic [ENGINES_CNT-1:0] disp_gnt;
   logic [ENGINES_CNT-1:0] rd_gnt;
   logic [PW-1:0]          disp_ptr;
   logic [PW-1:0]          rd_ptr;
   logic                   handshake;
   logic [A_WIDTH-1:0]     gnt_addr;
   logic [ENGINES_CNT-1:0] tag_pipe [RAM_LATENCY+1];

   assign idle         = ~eng_busy_i & ~pending;
   assign task_ready_o = |idle;
   assign handshake    = task_valid_i & task_ready_o;
   assign eng_rd_gnt_o = rd_gnt;

   rr_arbiter #(.N(ENGINES_CNT)) u_disp_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (idle),
      .advance (handshake),
      .gnt     (disp_gnt),
      .ptr     (disp_ptr)
   );

   rr_arbiter #(.N(ENGINES_CNT)) u_rd_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (eng_rd_req_i),
      .advance (|rd_gnt),
      .gnt     (rd_gnt),
      .ptr     (rd_ptr)
   );

   // Pending bridges the cycle between run and the engine raising busy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending        <= '0;
         eng_task_o     <= '0;
         eng_task_run_o <= '0;
      end else begin
         pending        <= (pending & ~eng_busy_i) | (handshake ? disp_gnt : '0);
         eng_task_run_o <= handshake ? disp_gnt : '0;
         if (handshake)
            eng_task_o <= task_i;
      end
   end

   always_comb begin
      gnt_addr = '0;
      for (int g = 0; g < ENGINES_CNT; g++)
         if (rd_gnt[g])
            gnt_addr = eng_rd_addr_i[g*A_WIDTH +: A_WIDTH];
   end

   // Grant tag travels alongside the RAM access and emerges with rd_data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         for (int k = 0; k <= RAM_LATENCY; k++)
            tag_pipe[k] <= '0;
      end else begin
         rd_en_o <= |rd_gnt;
         if (|rd_gnt)
            rd_addr_o <= gnt_addr;
         tag_pipe[0] <= rd_gnt;
         for (int k = 1; k <= RAM_LATENCY; k++)
            tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   assign eng_rd_data_val_o = tag_pipe[RAM_LATENCY];

   always_comb begin
      active_cnt_o = '0;
      for (int g = 0; g < ENGINES_CNT; g++)
         active_cnt_o = active_cnt_o + CW'(eng_busy_i[g] | pending[g]);
   end

endmodule

// File: tb/tb_data_table_search_sched.sv
// Directed bench for data_table_search_sched with a simple engine model that
// raises busy the cycle after its run strobe.
module tb_data_table_search_sched;
   import hash_table::*;

   localparam int N  = 3;
   localparam int AW = TABLE_ADDR_WIDTH;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   ht_task_t       task_in = '0;
   logic           task_valid = 1'b0;
   logic           task_ready;
   ht_task_t       eng_task;
   logic [N-1:0]   eng_run;
   logic [N-1:0]   eng_busy = '0;
   logic [N-1:0]   eng_rd_req = '0;
   logic [N*AW-1:0] eng_rd_addr;
   logic [N-1:0]   eng_rd_gnt;
   logic [N-1:0]   eng_rd_val;
   logic [AW-1:0]  rd_addr;
   logic           rd_en;
   logic [1:0]     active_cnt;

   logic [N-1:0]   run_seen = '0;
   logic [N-1:0]   set_mask = '0;
   logic [N-1:0]   drop_mask = '0;
   logic [AW-1:0]  addr_tbl [N];

   int vectors = 0;
   int miscompares = 0;

   data_table_search_sched dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .task_i            (task_in),
      .task_valid_i      (task_valid),
      .task_ready_o      (task_ready),
      .eng_task_o        (eng_task),
      .eng_task_run_o    (eng_run),
      .eng_busy_i        (eng_busy),
      .eng_rd_req_i      (eng_rd_req),
      .eng_rd_addr_i     (eng_rd_addr),
      .eng_rd_gnt_o      (eng_rd_gnt),
      .eng_rd_data_val_o (eng_rd_val),
      .rd_addr_o         (rd_addr),
      .rd_en_o           (rd_en),
      .active_cnt_o      (active_cnt)
   );

   initial forever #5 clk = ~clk;

   initial begin
      addr_tbl[0] = 10'h011;
      addr_tbl[1] = 10'h122;
      addr_tbl[2] = 10'h233;
   end
   assign eng_rd_addr = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};

   // Engine model: busy follows run by one cycle; bench can force/drop flags
   always @(negedge clk) run_seen = eng_run;
   always @(posedge clk) begin
      #1;
      if (rst) eng_busy = '0;
      else     eng_busy = (eng_busy | run_seen | set_mask) & ~drop_mask;
   end

   always @(posedge clk)
      if (!rst)
         assert ((eng_rd_req & ~eng_busy) == '0)
            else $error("[TB] read request from an engine that is not busy");

   function automatic ht_task_t mkTask(input int n);
      ht_task_t t;
      t.key          = KEY_WIDTH'(16'hA000 + n);
      t.head_ptr     = AW'(10'h040 + n);
      t.head_ptr_val = 1'b1;
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input ht_task_t t, input logic [N-1:0] req);
      @(negedge clk);
      set_mask   = '0;
      drop_mask  = '0;
      task_valid = v;
      task_in    = t;
      eng_rd_req = req;
      #1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      task_valid = 1'b0;
      eng_rd_req = '0;
      set_mask   = '0;
      drop_mask  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_run",    32'(eng_run),    0);
      checkOutput("rst_task",   32'(eng_task),   0);
      checkOutput("rst_rd_en",  32'(rd_en),      0);
      checkOutput("rst_addr",   32'(rd_addr),    0);
      checkOutput("rst_val",    32'(eng_rd_val), 0);
      checkOutput("rst_ready",  32'(task_ready), 1);
      checkOutput("rst_active", 32'(active_cnt), 0);
      resetDut();

      // Three back-to-back dispatches, fourth stalls until an engine frees
      applyStimulus(1, mkTask(0), '0);
      checkOutput("t1_ready0", 32'(task_ready), 1);
      checkOutput("t1_act0",   32'(active_cnt), 0);
      applyStimulus(1, mkTask(1), '0);
      checkOutput("t1_run0",   32'(eng_run), 3'b001);
      checkOutput("t1_task0",  32'(eng_task), 32'(mkTask(0)));
      checkOutput("t1_act1",   32'(active_cnt), 1);
      applyStimulus(1, mkTask(2), '0);
      checkOutput("t1_run1",   32'(eng_run), 3'b010);
      checkOutput("t1_task1",  32'(eng_task), 32'(mkTask(1)));
      checkOutput("t1_act2",   32'(active_cnt), 2);
      checkOutput("t1_ready2", 32'(task_ready), 1);
      applyStimulus(1, mkTask(3), '0);
      checkOutput("t1_run2",   32'(eng_run), 3'b100);
      checkOutput("t1_task2",  32'(eng_task), 32'(mkTask(2)));
      checkOutput("t1_act3",   32'(active_cnt), 3);
      checkOutput("t1_full",   32'(task_ready), 0);
      applyStimulus(1, mkTask(3), '0);
      checkOutput("t1_norun",  32'(eng_run), 0);
      checkOutput("t1_hold",   32'(eng_task), 32'(mkTask(2)));
      checkOutput("t1_stall",  32'(task_ready), 0);
      applyStimulus(1, mkTask(3), '0);
      drop_mask = 3'b010;
      checkOutput("t1_stall2", 32'(task_ready), 0);
      applyStimulus(1, mkTask(3), '0);
      checkOutput("t1_freed",  32'(task_ready), 1);
      checkOutput("t1_act4",   32'(active_cnt), 2);
      applyStimulus(0, '0, '0);
      checkOutput("t1_run3",   32'(eng_run), 3'b010);
      checkOutput("t1_task3",  32'(eng_task), 32'(mkTask(3)));

      // Only engine 1 idle with dp=0; then dp must point at engine 2
      resetDut();
      applyStimulus(0, '0, '0);
      set_mask = 3'b101;
      applyStimulus(1, mkTask(4), '0);
      checkOutput("t2_ready",  32'(task_ready), 1);
      checkOutput("t2_act",    32'(active_cnt), 2);
      applyStimulus(0, '0, '0);
      checkOutput("t2_run",    32'(eng_run), 3'b010);
      applyStimulus(0, '0, '0);
      drop_mask = 3'b111;
      applyStimulus(1, mkTask(5), '0);
      checkOutput("t2_allidle", 32'(active_cnt), 0);
      applyStimulus(0, '0, '0);
      checkOutput("t2_dp",     32'(eng_run), 3'b100);

      // Sustained reads from all engines rotate, tags return in order
      resetDut();
      applyStimulus(0, '0, '0);
      set_mask = 3'b111;
      for (int k = 0; k < 9; k++) begin
         applyStimulus(0, '0, (k < 6) ? 3'b111 : 3'b000);
         checkOutput($sformatf("t3_gnt%0d", k), 32'(eng_rd_gnt), (k < 6) ? (1 << (k % 3)) : 0);
         checkOutput($sformatf("t3_en%0d", k), 32'(rd_en), (k >= 1 && k <= 6) ? 1 : 0);
         if (k >= 1 && k <= 6)
            checkOutput($sformatf("t3_addr%0d", k), 32'(rd_addr), 32'(addr_tbl[(k-1) % 3]));
         checkOutput($sformatf("t3_val%0d", k), 32'(eng_rd_val), (k >= 3) ? (1 << ((k-3) % 3)) : 0);
      end

      // Single read from engine 2: rd_en at t+1, valid only at t+3
      applyStimulus(0, '0, 3'b100);
      checkOutput("t4_gnt",  32'(eng_rd_gnt), 3'b100);
      applyStimulus(0, '0, '0);
      checkOutput("t4_en1",  32'(rd_en), 1);
      checkOutput("t4_addr", 32'(rd_addr), 32'(addr_tbl[2]));
      checkOutput("t4_val1", 32'(eng_rd_val), 0);
      applyStimulus(0, '0, '0);
      checkOutput("t4_en2",  32'(rd_en), 0);
      checkOutput("t4_val2", 32'(eng_rd_val), 0);
      applyStimulus(0, '0, '0);
      checkOutput("t4_val3", 32'(eng_rd_val), 3'b100);
      applyStimulus(0, '0, '0);
      checkOutput("t4_val4", 32'(eng_rd_val), 0);

      // Reset with two reads in flight: no stray strobes, rp back to engine 0
      applyStimulus(0, '0, 3'b001);
      checkOutput("t5_gnt0", 32'(eng_rd_gnt), 3'b001);
      applyStimulus(0, '0, 3'b010);
      checkOutput("t5_gnt1", 32'(eng_rd_gnt), 3'b010);
      applyStimulus(0, '0, '0);
      rst = 1'b1;
      #1;
      checkOutput("t5_en_rst", 32'(rd_en), 0);
      checkOutput("t5_val2",   32'(eng_rd_val), 0);
      applyStimulus(0, '0, '0);
      checkOutput("t5_val3",   32'(eng_rd_val), 0);
      applyStimulus(0, '0, '0);
      checkOutput("t5_val4",   32'(eng_rd_val), 0);
      applyStimulus(0, '0, '0);
      rst = 1'b0;
      set_mask = 3'b111;
      checkOutput("t5_val5",   32'(eng_rd_val), 0);
      applyStimulus(0, '0, 3'b111);
      checkOutput("t5_first",  32'(eng_rd_gnt), 3'b001);
      checkOutput("t5_val6",   32'(eng_rd_val), 0);

      // Dispatch and read arbitration in the same cycle
      resetDut();
      applyStimulus(0, '0, '0);
      set_mask = 3'b101;
      applyStimulus(0, '0, 3'b001);
      checkOutput("t6_gnt0",  32'(eng_rd_gnt), 3'b001);
      checkOutput("t6_act0",  32'(active_cnt), 2);
      applyStimulus(1, mkTask(6), 3'b101);
      checkOutput("t6_ready", 32'(task_ready), 1);
      checkOutput("t6_gnt1",  32'(eng_rd_gnt), 3'b100);
      checkOutput("t6_act1",  32'(active_cnt), 2);
      applyStimulus(0, '0, 3'b001);
      checkOutput("t6_run",   32'(eng_run), 3'b010);
      checkOutput("t6_task",  32'(eng_task), 32'(mkTask(6)));
      checkOutput("t6_en",    32'(rd_en), 1);
      checkOutput("t6_addr2", 32'(rd_addr), 32'(addr_tbl[2]));
      checkOutput("t6_gnt2",  32'(eng_rd_gnt), 3'b001);
      checkOutput("t6_act2",  32'(active_cnt), 3);
      applyStimulus(0, '0, '0);
      checkOutput("t6_gnt3",  32'(eng_rd_gnt), 0);
      checkOutput("t6_addr0", 32'(rd_addr), 32'(addr_tbl[0]));
      checkOutput("t6_act3",  32'(active_cnt), 3);
      checkOutput("t6_full",  32'(task_ready), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
